// File: rtl/counter_sequencer_if.sv
// Command, load and status signals between control logic and counter_sequencer.
// master drives commands and the load offer; slave is the sequencer.
interface counter_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             clear;
    logic             reload;
    logic             load_valid;
    logic [WIDTH-1:0] load_value;
    logic             load_ready;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, clear, reload, load_valid, load_value,
        input  load_ready, count, busy, done
    );

    modport slave (
        input  start, stop, clear, reload, load_valid, load_value,
        output load_ready, count, busy, done
    );
endinterface

// File: rtl/counter_sequencer.sv
// Programmable modulo counter with start/pause/resume/clear, prescaled ticks,
// one-shot or auto-reload terminal count, and a registered done pulse.
module counter_sequencer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                reset_b,
    counter_sequencer_if.slave  bus
);
    localparam int             PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             done_q,  done_d;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= S_IDLE;
            count_q <= '0;
            limit_q <= '1;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        presc_d = presc_q;
        done_d  = 1'b0;

        if (bus.clear) begin
            state_d = S_IDLE;
            count_d = '0;
            presc_d = '0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    // stop takes priority over a tick on the same edge, so a paused count never skips
                    if (bus.stop) begin
                        state_d = S_PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (count_q == limit_q) begin
                            done_d = 1'b1;
                            if (bus.reload) begin
                                count_d = '0;
                            end else begin
                                state_d = S_DONE;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (bus.start) begin
                        state_d = S_RUN;
                    end
                end
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_d = S_RUN;
                        count_d = '0;
                        presc_d = '0;
                    end else if (bus.load_valid) begin
                        limit_d = bus.load_value;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.busy       = (state_q == S_RUN) || (state_q == S_PAUSE);
        bus.load_ready = (state_q == S_IDLE) || (state_q == S_DONE);
        bus.count      = count_q;
        bus.done       = done_q;
    end
endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: vector table at PRESCALE=1 plus
// hand-written sequences for async reset and PRESCALE=3.
module tb_counter_sequencer;
    logic clk = 1'b0;
    logic reset_b = 1'b0;

    counter_sequencer_if #(.WIDTH(4)) ifa ();
    counter_sequencer_if #(.WIDTH(4)) ifb ();

    counter_sequencer #(.WIDTH(4), .PRESCALE(1)) u_a (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (ifa.slave)
    );

    counter_sequencer #(.WIDTH(4), .PRESCALE(3)) u_b (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (ifb.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic       clear;
        logic       reload;
        logic       lv;
        logic [3:0] lval;
        logic [3:0] ecount;
        logic       ebusy;
        logic       edone;
        logic       eready;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic st, logic sp, logic cl, logic rl, logic lv,
                                logic [3:0] lval, logic [3:0] c, logic b,
                                logic d, logic r);
        vec_t v;
        v.start = st; v.stop = sp; v.clear = cl; v.reload = rl; v.lv = lv;
        v.lval = lval; v.ecount = c; v.ebusy = b; v.edone = d; v.eready = r;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] status_a();
        return {ifa.count, ifa.busy, ifa.done, ifa.load_ready};
    endfunction

    function automatic logic [6:0] status_b();
        return {ifb.count, ifb.busy, ifb.done, ifb.load_ready};
    endfunction

    task automatic idle_a();
        ifa.start = 0; ifa.stop = 0; ifa.clear = 0; ifa.reload = 0;
        ifa.load_valid = 0; ifa.load_value = '0;
    endtask

    task automatic idle_b();
        ifb.start = 0; ifb.stop = 0; ifb.clear = 0; ifb.reload = 0;
        ifb.load_valid = 0; ifb.load_value = '0;
    endtask

    initial begin
        idle_a();
        idle_b();

        // one-shot, limit 9
        vecs.push_back(mk(0,0,0,0,1,4'd9, 4'd0,0,0,1));
        vecs.push_back(mk(1,0,0,0,0,4'd0, 4'd0,1,0,0));
        for (int i = 1; i <= 9; i++) vecs.push_back(mk(0,0,0,0,0,0, 4'(i),1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 4'd9,0,1,1));
        vecs.push_back(mk(0,0,0,0,0,0, 4'd9,0,0,1));
        // auto-reload, limit 3, loaded while DONE
        vecs.push_back(mk(0,0,0,0,1,4'd3, 4'd9,0,0,1));
        vecs.push_back(mk(1,0,0,1,0,0, 4'd0,1,0,0));
        for (int r = 0; r < 2; r++) begin
            vecs.push_back(mk(0,0,0,1,0,0, 4'd1,1,0,0));
            vecs.push_back(mk(0,0,0,1,0,0, 4'd2,1,0,0));
            vecs.push_back(mk(0,0,0,1,0,0, 4'd3,1,0,0));
            vecs.push_back(mk(0,0,0,1,0,0, 4'd0,1,1,0));
        end
        vecs.push_back(mk(0,0,1,0,0,0, 4'd0,0,0,1));
        // pause/resume, limit 5; load offered while paused is ignored
        vecs.push_back(mk(0,0,0,0,1,4'd5, 4'd0,0,0,1));
        vecs.push_back(mk(1,0,0,0,0,0, 4'd0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 4'd1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 4'd2,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 4'd2,1,0,0));
        vecs.push_back(mk(0,0,0,0,1,4'd1, 4'd2,1,0,0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,0,0,0,0, 4'd2,1,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 4'd2,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 4'd3,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 4'd4,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 4'd5,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 4'd5,0,1,1));
        // clear+start at count 4, limit retained
        vecs.push_back(mk(1,0,0,0,0,0, 4'd0,1,0,0));
        for (int i = 1; i <= 4; i++) vecs.push_back(mk(0,0,0,0,0,0, 4'(i),1,0,0));
        vecs.push_back(mk(1,0,1,0,0,0, 4'd0,0,0,1));
        vecs.push_back(mk(1,0,0,0,0,0, 4'd0,1,0,0));
        for (int i = 1; i <= 5; i++) vecs.push_back(mk(0,0,0,0,0,0, 4'(i),1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 4'd5,0,1,1));
        // limit 0 with reload: done every cycle until stop
        vecs.push_back(mk(0,0,0,0,1,4'd0, 4'd5,0,0,1));
        vecs.push_back(mk(1,0,0,1,0,0, 4'd0,1,0,0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,1,0,0, 4'd0,1,1,0));
        vecs.push_back(mk(0,1,0,1,0,0, 4'd0,1,0,0));
        vecs.push_back(mk(1,0,0,1,0,0, 4'd0,1,0,0));
        vecs.push_back(mk(0,0,0,1,0,0, 4'd0,1,1,0));
        // start+stop: stop wins in RUN, start wins in PAUSE
        vecs.push_back(mk(1,1,0,1,0,0, 4'd0,1,0,0));
        vecs.push_back(mk(1,1,0,1,0,0, 4'd0,1,0,0));
        vecs.push_back(mk(0,0,0,1,0,0, 4'd0,1,1,0));
        vecs.push_back(mk(0,0,1,0,0,0, 4'd0,0,0,1));

        #2;
        check("reset_a", 32'(status_a()), 32'(7'b0000_001));
        check("reset_b", 32'(status_b()), 32'(7'b0000_001));
        @(negedge clk);
        reset_b = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            ifa.start = vecs[i].start; ifa.stop = vecs[i].stop;
            ifa.clear = vecs[i].clear; ifa.reload = vecs[i].reload;
            ifa.load_valid = vecs[i].lv; ifa.load_value = vecs[i].lval;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), 32'(status_a()),
                  32'({vecs[i].ecount, vecs[i].ebusy, vecs[i].edone, vecs[i].eready}));
        end

        // async reset mid-run must also restore limit to all ones
        @(negedge clk);
        idle_a();
        ifa.load_valid = 1; ifa.load_value = 4'd7;
        @(negedge clk);
        idle_a();
        ifa.start = 1;
        @(negedge clk);
        idle_a();
        repeat (3) @(posedge clk);
        #3;
        check("pre_reset_cnt", 32'(ifa.count), 32'd3);
        reset_b = 1'b0;
        #1;
        check("async_reset", 32'(status_a()), 32'(7'b0000_001));
        #2;
        reset_b = 1'b1;
        @(negedge clk);
        ifa.start = 1;
        @(posedge clk);
        #1;
        check("restart", 32'(status_a()), 32'(7'b0000_100));
        @(negedge clk);
        idle_a();
        repeat (15) @(posedge clk);
        #1;
        check("lim15_cnt", 32'(status_a()), 32'({4'd15, 1'b1, 1'b0, 1'b0}));
        @(posedge clk);
        #1;
        check("lim15_done", 32'(status_a()), 32'({4'd15, 1'b0, 1'b1, 1'b1}));

        // PRESCALE=3, limit 2, one-shot: done 9 edges after the start edge
        @(negedge clk);
        ifb.load_valid = 1; ifb.load_value = 4'd2;
        @(negedge clk);
        idle_b();
        ifb.start = 1;
        @(posedge clk);
        #1;
        check("p3_start", 32'(status_b()), 32'(7'b0000_100));
        @(negedge clk);
        idle_b();
        for (int k = 1; k <= 9; k++) begin
            logic [3:0] ec;
            ec = (k < 3) ? 4'd0 : (k < 6) ? 4'd1 : 4'd2;
            @(posedge clk);
            #1;
            check($sformatf("p3_edge%0d", k), 32'(status_b()),
                  32'({ec, (k != 9), (k == 9), (k == 9)}));
        end
        @(posedge clk);
        #1;
        check("p3_after", 32'(status_b()), 32'({4'd2, 1'b0, 1'b0, 1'b1}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
